hazard_unit: RTL and testbench

Pipeline hazard controller for the 5-stage core. It watches the ID-stage source registers and the ID/EX register outputs, and generates the `bubble` input of the ID/EX register. It also produces the PC and IF/ID write enables and the EX-stage forwarding selects. It keeps private shadow copies of the MEM- and WB-stage destination info, and runs a small stall FSM that stretches byte-load stalls to two cycles.

---
 rtl/hazard_pkg.sv | 28 ++
 rtl/hazard_unit_fwd_select.sv | 28 ++
 rtl/hazard_unit.sv | 129 ++++++++++++
 tb/tb_hazard_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the forward-select codes, the stall FSM states and the shadow-stage record.
package hazard_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        RUN       = 1'b0,
        BYTE_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic [4:0] dest;
        logic       regwrite;
        logic       memtoreg;
        logic [1:0] loadbyte;
    } shadow_t;

    localparam int SHADOW_W = $bits(shadow_t);

    // Register 0 is hard-wired to zero, so it never produces a dependency.
    function automatic logic dest_match(input logic [4:0] dest, input logic [4:0] src);
        return (dest != 5'd0) && (dest == src);
    endfunction

endpackage

// File: rtl/hazard_unit_fwd_select.sv
// Per-operand EX forwarding select from the MEM and WB shadow stages.
// MEM is the younger producer and therefore wins over WB.
module fwd_select
    import hazard_pkg::*;
(
    input  logic [4:0]          src,
    input  logic [SHADOW_W-1:0] mem_shadow,
    input  logic [SHADOW_W-1:0] wb_shadow,
    output logic [1:0]          sel
);

    shadow_t mem_s;
    shadow_t wb_s;

    assign mem_s = shadow_t'(mem_shadow);
    assign wb_s  = shadow_t'(wb_shadow);

    // A load in MEM has no data yet; a byte load in WB is only readable via the register file.
    always_comb begin
        sel = FWD_REG;
        if (mem_s.regwrite && !mem_s.memtoreg && dest_match(mem_s.dest, src)) begin
            sel = FWD_MEM;
        end else if (wb_s.regwrite && (wb_s.loadbyte == 2'b00) && dest_match(wb_s.dest, src)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Load-use stall controller and EX forwarding logic for the 5-stage core.
// Byte loads stall for two cycles, word loads for one; stalls are counted (saturating).
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int CNT_W = 32
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs_a,
    input  logic [4:0]       id_rt_a,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_rs_a,
    input  logic [4:0]       ex_rt_a,
    input  logic [4:0]       ex_rd_a,
    input  logic             ex_regdst,
    input  logic             ex_regwrite,
    input  logic             ex_memtoreg,
    input  logic [1:0]       ex_loadbyte,
    output logic             bubble,
    output logic             pc_write,
    output logic             ifid_write,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cycles
);

    logic [4:0]       ex_dest;
    logic             lu_hit;
    logic             stall;
    shadow_t          ex_shadow;
    shadow_t          mem_reg;
    shadow_t          wb_reg;
    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] stall_cycles_reg;
    logic [CNT_W-1:0] stall_cycles_next;
    logic [4:0]       fwd_src [2];
    logic [1:0]       fwd_sel [2];

    assign ex_dest = ex_regdst ? ex_rd_a : ex_rt_a;

    assign ex_shadow.dest     = ex_dest;
    assign ex_shadow.regwrite = ex_regwrite;
    assign ex_shadow.memtoreg = ex_memtoreg;
    assign ex_shadow.loadbyte = ex_loadbyte;

    assign lu_hit = ex_memtoreg && ex_regwrite &&
                    (dest_match(ex_dest, id_rs_a) || (id_uses_rt && dest_match(ex_dest, id_rt_a)));

    // Shadows track the real pipeline unconditionally; a bubbled ID/EX feeds zeros in.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_reg <= '0;
            wb_reg  <= '0;
        end else begin
            mem_reg <= ex_shadow;
            wb_reg  <= mem_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        stall      = lu_hit;
        case (state_reg)
            RUN: begin
                if (lu_hit && (ex_loadbyte != 2'b00)) begin
                    state_next = BYTE_WAIT;
                end
            end
            BYTE_WAIT: begin
                stall      = 1'b1;
                state_next = RUN;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    assign bubble     = stall;
    assign pc_write   = ~stall;
    assign ifid_write = ~stall;

    always_comb begin
        stall_cycles_next = stall_cycles_reg;
        if (stall && (stall_cycles_reg != {CNT_W{1'b1}})) begin
            stall_cycles_next = stall_cycles_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_reg <= '0;
        end else begin
            stall_cycles_reg <= stall_cycles_next;
        end
    end

    assign stall_cycles = stall_cycles_reg;

    assign fwd_src[0] = ex_rs_a;
    assign fwd_src[1] = ex_rt_a;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            fwd_select u_fwd (
                .src        (fwd_src[gi]),
                .mem_shadow (mem_reg),
                .wb_shadow  (wb_reg),
                .sel        (fwd_sel[gi])
            );
        end
    endgenerate

    assign fwd_a = fwd_sel[0];
    assign fwd_b = fwd_sel[1];

endmodule

// File: tb/tb_hazard_unit.sv
// Directed scenarios plus randomized traffic for hazard_unit, checked against an
// instruction-history reference model (narrow counter so saturation is reached).
module tb_hazard_unit;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    id_rs_a, id_rt_a;
    logic          id_uses_rt;
    logic [4:0]    ex_rs_a, ex_rt_a, ex_rd_a;
    logic          ex_regdst, ex_regwrite, ex_memtoreg;
    logic [1:0]    ex_loadbyte;
    logic          bubble, pc_write, ifid_write;
    logic [1:0]    fwd_a, fwd_b;
    logic [CW-1:0] stall_cycles;

    int total = 0;
    int bad   = 0;

    // Reference model: the last two instructions that left EX (index 1 = one cycle ago).
    int h_dest [1:2];
    int h_rw   [1:2];
    int h_mtr  [1:2];
    int h_lb   [1:2];
    int m_extra_stalls = 0;
    int m_count = 0;

    logic          obs_bubble, obs_pc;
    logic [1:0]    obs_fa, obs_fb;
    logic [CW-1:0] obs_cnt;

    hazard_unit #(.CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs_a      (id_rs_a),
        .id_rt_a      (id_rt_a),
        .id_uses_rt   (id_uses_rt),
        .ex_rs_a      (ex_rs_a),
        .ex_rt_a      (ex_rt_a),
        .ex_rd_a      (ex_rd_a),
        .ex_regdst    (ex_regdst),
        .ex_regwrite  (ex_regwrite),
        .ex_memtoreg  (ex_memtoreg),
        .ex_loadbyte  (ex_loadbyte),
        .bubble       (bubble),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int ex_dest_m();
        return ex_regdst ? int'(ex_rd_a) : int'(ex_rt_a);
    endfunction

    function automatic bit model_hit();
        int d = ex_dest_m();
        if (!(ex_memtoreg && ex_regwrite) || d == 0) return 1'b0;
        return (d == int'(id_rs_a)) || (id_uses_rt && d == int'(id_rt_a));
    endfunction

    function automatic int model_fwd(input int src);
        if (h_rw[1] != 0 && h_mtr[1] == 0 && h_dest[1] != 0 && h_dest[1] == src) return 2;
        if (h_rw[2] != 0 && h_lb[2] == 0 && h_dest[2] != 0 && h_dest[2] == src) return 1;
        return 0;
    endfunction

    task automatic set_ex(input int dest, input bit use_rd, input bit rw, input bit mtr, input int lb);
        ex_regdst   = use_rd;
        ex_rd_a     = use_rd ? 5'(dest) : 5'd0;
        ex_rt_a     = use_rd ? 5'd0 : 5'(dest);
        ex_rs_a     = 5'd0;
        ex_regwrite = rw;
        ex_memtoreg = mtr;
        ex_loadbyte = 2'(lb);
    endtask

    task automatic set_id(input int rs, input int rt, input bit uses);
        id_rs_a    = 5'(rs);
        id_rt_a    = 5'(rt);
        id_uses_rt = uses;
    endtask

    // One clock: check all outputs against the model at negedge, then advance the model.
    task automatic step(input string tag);
        bit hit, exp_stall;
        int fa, fb;
        @(negedge clk);
        hit       = model_hit();
        exp_stall = hit || (m_extra_stalls > 0);
        fa        = model_fwd(int'(ex_rs_a));
        fb        = model_fwd(int'(ex_rt_a));
        obs_bubble = bubble;
        obs_pc     = pc_write;
        obs_fa     = fwd_a;
        obs_fb     = fwd_b;
        obs_cnt    = stall_cycles;
        check_val({tag, ".bubble"}, 32'(bubble), 32'(exp_stall));
        check_val({tag, ".pc_write"}, 32'(pc_write), 32'(!exp_stall));
        check_val({tag, ".ifid_write"}, 32'(ifid_write), 32'(!exp_stall));
        check_val({tag, ".fwd_a"}, 32'(fwd_a), 32'(fa));
        check_val({tag, ".fwd_b"}, 32'(fwd_b), 32'(fb));
        check_val({tag, ".stall_cycles"}, 32'(stall_cycles), 32'(m_count));
        $display("%s: rst=%0b hit=%0b bubble=%0b fwd_a=%0d fwd_b=%0d cnt=%0d",
                 tag, reset, hit, bubble, fwd_a, fwd_b, stall_cycles);
        @(posedge clk);
        if (reset) begin
            for (int i = 1; i <= 2; i++) begin
                h_dest[i] = 0; h_rw[i] = 0; h_mtr[i] = 0; h_lb[i] = 0;
            end
            m_extra_stalls = 0;
            m_count = 0;
        end else begin
            if (exp_stall && m_count < (1 << CW) - 1) m_count++;
            if (m_extra_stalls > 0) m_extra_stalls--;
            else if (hit && ex_loadbyte != 2'b00) m_extra_stalls = 1;
            h_dest[2] = h_dest[1]; h_rw[2] = h_rw[1]; h_mtr[2] = h_mtr[1]; h_lb[2] = h_lb[1];
            h_dest[1] = ex_dest_m(); h_rw[1] = int'(ex_regwrite);
            h_mtr[1] = int'(ex_memtoreg); h_lb[1] = int'(ex_loadbyte);
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_ex(0, 0, 0, 0, 0);
        set_id(0, 0, 0);
        step("reset");
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 1; i <= 2; i++) begin
            h_dest[i] = 0; h_rw[i] = 0; h_mtr[i] = 0; h_lb[i] = 0;
        end
        reset = 1'b1;
        set_ex(0, 0, 0, 0, 0);
        set_id(0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        step("reset_state");
        check_val("reset_state.bubble_const", 32'(obs_bubble), 32'd0);
        check_val("reset_state.pc_const", 32'(obs_pc), 32'd1);
        reset = 1'b0;

        // Word-load hit: one stall, then WB forwarding.
        set_ex(5, 0, 1, 1, 0); set_id(5, 0, 0);
        step("word.hit");
        check_val("word.hit_bubble", 32'(obs_bubble), 32'd1);
        check_val("word.hit_pc", 32'(obs_pc), 32'd0);
        set_ex(0, 0, 0, 0, 0);
        step("word.bubble");
        check_val("word.released", 32'(obs_bubble), 32'd0);
        set_ex(9, 1, 1, 0, 0); ex_rs_a = 5'd5; set_id(0, 0, 0);
        step("word.dep");
        check_val("word.fwd_a_wb", 32'(obs_fa), 32'd1);

        // Byte-load hit: two stalls, no forwarding afterwards.
        do_reset();
        set_ex(5, 0, 1, 1, 1); set_id(0, 5, 1);
        step("byte.hit");
        check_val("byte.stall1", 32'(obs_bubble), 32'd1);
        set_ex(0, 0, 0, 0, 0);
        step("byte.wait");
        check_val("byte.stall2", 32'(obs_bubble), 32'd1);
        step("byte.release");
        check_val("byte.released", 32'(obs_bubble), 32'd0);
        set_ex(9, 1, 1, 0, 0); ex_rt_a = 5'd5; ex_rd_a = 5'd9;
        set_id(0, 0, 0);
        step("byte.dep");
        check_val("byte.fwd_b_reg", 32'(obs_fb), 32'd0);
        check_val("byte.count", 32'(obs_cnt), 32'd2);

        // Forward priority: MEM beats WB; WB alone gives 01.
        set_ex(3, 1, 1, 0, 0); step("prio.add1");
        set_ex(3, 1, 1, 0, 0); step("prio.add2");
        set_ex(0, 0, 0, 0, 0); ex_rs_a = 5'd3; step("prio.use");
        check_val("prio.fwd_a_mem", 32'(obs_fa), 32'd2);
        set_ex(3, 1, 1, 0, 0); step("prio1.add");
        set_ex(0, 0, 0, 0, 0); step("prio1.nop");
        ex_rs_a = 5'd3; step("prio1.use");
        check_val("prio1.fwd_a_wb", 32'(obs_fa), 32'd1);

        // Register 0 is never a hazard nor forwarded.
        set_ex(0, 0, 1, 1, 0); set_id(0, 0, 1);
        step("r0.lw");
        check_val("r0.no_bubble", 32'(obs_bubble), 32'd0);
        set_ex(0, 0, 1, 0, 0); step("r0.mid");
        set_ex(0, 0, 0, 0, 0); step("r0.use");
        check_val("r0.fwd_a", 32'(obs_fa), 32'd0);

        // ID does not read rt: matching rt is not a hazard.
        set_ex(7, 0, 1, 1, 0); set_id(2, 7, 0);
        step("nort.lw");
        check_val("nort.no_bubble", 32'(obs_bubble), 32'd0);

        // Reset during BYTE_WAIT clears the stall.
        set_ex(5, 0, 1, 1, 2); set_id(5, 0, 0);
        step("rstmid.hit");
        set_ex(0, 0, 0, 0, 0); set_id(0, 0, 0); reset = 1'b1;
        step("rstmid.wait");
        check_val("rstmid.in_wait", 32'(obs_bubble), 32'd1);
        reset = 1'b0;
        step("rstmid.after");
        check_val("rstmid.bubble", 32'(obs_bubble), 32'd0);
        check_val("rstmid.pc", 32'(obs_pc), 32'd1);
        check_val("rstmid.count", 32'(obs_cnt), 32'd0);

        // Random traffic over a small register range to provoke frequent hazards.
        for (int n = 0; n < 600; n++) begin
            reset       = ($urandom_range(0, 59) == 0);
            id_rs_a     = 5'($urandom_range(0, 7));
            id_rt_a     = 5'($urandom_range(0, 7));
            id_uses_rt  = 1'($urandom_range(0, 1));
            ex_rs_a     = 5'($urandom_range(0, 7));
            ex_rt_a     = 5'($urandom_range(0, 7));
            ex_rd_a     = 5'($urandom_range(0, 7));
            ex_regdst   = 1'($urandom_range(0, 1));
            ex_regwrite = ($urandom_range(0, 3) != 0);
            ex_memtoreg = 1'($urandom_range(0, 1));
            ex_loadbyte = 2'($urandom_range(0, 3));
            step($sformatf("rand%0d", n));
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
